// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit free-running mtime, 64-bit mtimecmp, and a
// registered timer-interrupt-pending level, accessed over a word-wide req/ack bus.
module mtimer #(
  parameter int XLEN     = 32,
  parameter int PRESCALE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic            i_we,
  input  logic [4:0]      i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_ack,
  output logic            o_Int_tip
);

  localparam int            CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] PRE_MAX = CW'(PRESCALE - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t          state, state_nxt;
  logic [63:0]     mtime, mtimecmp;
  logic [CW-1:0]   pre_cnt;
  logic [XLEN-1:0] rdata_q, rd_mux;
  logic [2:0]      word;
  logic            access;
  logic            wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi;
  logic            unused_addr;

  // Byte-lane bits carry no meaning on a word-only bus.
  assign unused_addr = ^i_addr[1:0];

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    word       = i_addr[4:2];
    access     = (state == IDLE) && i_req;
    wr_time_lo = access && i_we && (word == 3'd0);
    wr_time_hi = access && i_we && (word == 3'd1);
    wr_cmp_lo  = access && i_we && (word == 3'd2);
    wr_cmp_hi  = access && i_we && (word == 3'd3);
    rd_mux     = '0;
    case (word)
      3'd0:    rd_mux = mtime[XLEN-1:0];
      3'd1:    rd_mux = mtime[63:XLEN];
      3'd2:    rd_mux = mtimecmp[XLEN-1:0];
      3'd3:    rd_mux = mtimecmp[63:XLEN];
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    o_ack     = 1'b0;
    o_rdata   = '0;
    case (state)
      IDLE: if (i_req) state_nxt = ACK;
      ACK: begin
        // The request line is deliberately ignored here; a held request is
        // only picked up again once back in IDLE.
        state_nxt = IDLE;
        o_ack     = 1'b1;
        o_rdata   = rdata_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of block order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Read data is captured from the pre-edge register contents.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      rdata_q <= '0;
    else if (access) rdata_q <= rd_mux;
  end

  // A software write to mtime overrides the tick and restarts the prescaler.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mtime   <= '0;
      pre_cnt <= '0;
    end else if (wr_time_lo || wr_time_hi) begin
      if (wr_time_lo) mtime[XLEN-1:0] <= i_wdata;
      if (wr_time_hi) mtime[63:XLEN]  <= i_wdata;
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
      mtime   <= mtime + 64'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mtimecmp  <= '1;
      o_Int_tip <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[XLEN-1:0] <= i_wdata;
      if (wr_cmp_hi) mtimecmp[63:XLEN]  <= i_wdata;
      o_Int_tip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: PRESCALE=1 and PRESCALE=4 instances checked
// against a closed-form time model (mtime = base + elapsed_cycles / PRESCALE).
module tb_mtimer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        sel = 1'b0;

  logic [31:0] rdata1, rdata4;
  logic        ack1, ack4, tip1, tip4;
  logic        req1, req4;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  assign req1 = req && !sel;
  assign req4 = req && sel;

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  mtimer #(.XLEN(32), .PRESCALE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata1), .o_ack(ack1), .o_Int_tip(tip1)
  );

  mtimer #(.XLEN(32), .PRESCALE(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_req(req4), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata4), .o_ack(ack4), .o_Int_tip(tip4)
  );

  // Reference model: mtime is a linear function of the edge count since the
  // last load; one level of history covers the edge of a write.
  int          pscl[2] = '{1, 4};
  logic [63:0] base_val[2], old_val[2], cmp_cur[2], cmp_old[2];
  int          base_cyc[2], old_cyc[2], cmp_cyc[2];

  function automatic logic [63:0] mval(input int d, input int n);
    if (n >= base_cyc[d]) return base_val[d] + 64'((n - base_cyc[d]) / pscl[d]);
    return old_val[d] + 64'((n - old_cyc[d]) / pscl[d]);
  endfunction

  function automatic logic [63:0] cmp_at(input int d, input int n);
    return (n >= cmp_cyc[d]) ? cmp_cur[d] : cmp_old[d];
  endfunction

  function automatic logic tip_model(input int d, input int n);
    return mval(d, n - 1) >= cmp_at(d, n - 1);
  endfunction

  function automatic logic [31:0] model_read(input int d, input int w, input int n);
    logic [63:0] v;
    v = '0;
    if (w == 0 || w == 1) v = mval(d, n);
    else if (w == 2 || w == 3) v = cmp_at(d, n);
    if (w == 0 || w == 2) return v[31:0];
    if (w == 1 || w == 3) return v[63:32];
    return 32'd0;
  endfunction

  task automatic model_reset(input int d);
    base_val[d] = '0;  old_val[d] = '0;
    base_cyc[d] = ncyc; old_cyc[d] = ncyc;
    cmp_cur[d]  = '1;  cmp_old[d] = '1;
    cmp_cyc[d]  = ncyc;
  endtask

  task automatic model_write(input int d, input int w, input logic [31:0] wd, input int e);
    logic [63:0] cur;
    if (w == 0 || w == 1) begin
      cur         = mval(d, e - 1);
      old_val[d]  = base_val[d];
      old_cyc[d]  = base_cyc[d];
      base_val[d] = (w == 0) ? {cur[63:32], wd} : {wd, cur[31:0]};
      base_cyc[d] = e;
    end else if (w == 2 || w == 3) begin
      cmp_old[d] = cmp_cur[d];
      cmp_cyc[d] = e;
      cmp_cur[d] = (w == 2) ? {cmp_cur[d][63:32], wd} : {wd, cmp_cur[d][31:0]};
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  task automatic check_tips();
    check("tip_p1", 64'(tip1), 64'(tip_model(0, ncyc)));
    check("tip_p4", 64'(tip4), 64'(tip_model(1, ncyc)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_tips();
    end
  endtask

  function automatic logic cur_ack(input int d);
    return (d == 0) ? ack1 : ack4;
  endfunction

  function automatic logic [31:0] cur_rdata(input int d);
    return (d == 0) ? rdata1 : rdata4;
  endfunction

  // One bus access: request driven at a falling edge, acked one cycle later.
  task automatic access(input int d, input bit w_en, input logic [4:0] a,
                        input logic [31:0] wd);
    logic [31:0] exp_rd;
    int          w;
    w      = int'(a[4:2]);
    exp_rd = model_read(d, w, ncyc);
    sel = d[0]; we = w_en; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (w_en) model_write(d, w, wd, ncyc);
    check("ack", 64'(cur_ack(d)), 64'd1);
    if (!w_en || w >= 4) check("rdata", 64'(cur_rdata(d)), 64'(w_en ? 32'd0 : exp_rd));
    check_tips();
    req = 1'b0;
    @(negedge clk);
    check("ack_low", 64'(cur_ack(d)), 64'd0);
    check("rdata_idle", 64'(cur_rdata(d)), 64'd0);
    check_tips();
  endtask

  initial begin
    logic [31:0] exp_rd;
    int          w;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack1 | ack4), 64'd0);
    check("rst_rdata", 64'(rdata1 | rdata4), 64'd0);
    check("rst_tip", 64'(tip1 | tip4), 64'd0);
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    idle(2);

    // Compare register reads back all-ones after reset
    access(0, 1'b0, 5'h08, '0);
    access(0, 1'b0, 5'h0C, '0);
    access(1, 1'b0, 5'h08, '0);
    access(1, 1'b0, 5'h0F, '0);

    // Interrupt rises when mtime reaches mtimecmp, falls when cmp moves past
    access(0, 1'b1, 5'h00, 32'd0);
    access(0, 1'b1, 5'h08, 32'h20);
    access(0, 1'b1, 5'h0C, 32'h0);
    idle(40);
    access(0, 1'b1, 5'h08, 32'h1000);
    idle(3);

    // Low-half carry into high half, and full 64-bit wrap
    access(0, 1'b1, 5'h04, 32'h0);
    access(0, 1'b1, 5'h00, 32'hFFFF_FFFF);
    access(0, 1'b0, 5'h04, '0);
    access(0, 1'b0, 5'h00, '0);
    access(0, 1'b1, 5'h08, 32'h40);
    access(0, 1'b1, 5'h04, 32'hFFFF_FFFF);
    access(0, 1'b1, 5'h00, 32'hFFFF_FFFF);
    idle(3);
    access(0, 1'b0, 5'h00, '0);
    access(0, 1'b0, 5'h04, '0);
    idle(70);

    // PRESCALE=4: ticks every fourth cycle after a load; reads at every phase
    access(1, 1'b1, 5'h04, 32'h0);
    access(1, 1'b1, 5'h00, 32'h0);
    access(1, 1'b0, 5'h00, '0);
    idle(1);
    for (int i = 0; i < 6; i++) access(1, 1'b0, 5'h00, '0);

    // Unmapped offsets are acked, read zero, and change nothing
    access(0, 1'b0, 5'h10, '0);
    access(0, 1'b1, 5'h14, 32'hDEAD_BEEF);
    access(1, 1'b1, 5'h1C, 32'h1234_5678);
    for (int i = 0; i < 4; i++) access(0, 1'b0, 5'(i * 4), '0);

    // Request held through ACK: next access starts only in the following IDLE
    exp_rd = model_read(0, 2, ncyc);
    sel = 1'b0; we = 1'b0; addr = 5'h08; req = 1'b1;
    @(posedge clk); @(negedge clk);
    check("hold_ack1", 64'(ack1), 64'd1);
    check("hold_rd1", 64'(rdata1), 64'(exp_rd));
    @(posedge clk); @(negedge clk);
    check("hold_gap", 64'(ack1), 64'd0);
    @(posedge clk); @(negedge clk);
    check("hold_ack2", 64'(ack1), 64'd1);
    check("hold_rd2", 64'(rdata1), 64'(exp_rd));
    req = 1'b0;
    @(negedge clk);
    check("hold_end", 64'(ack1), 64'd0);
    check_tips();

    // Randomized accesses against the model
    for (int i = 0; i < 150; i++) begin
      logic [4:0]  a;
      logic [31:0] wd;
      a  = 5'($urandom_range(0, 31));
      w  = int'(a[4:2]);
      wd = (w == 1 || w == 3) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      idle(int'($urandom_range(0, 3)));
    end

    // Force interrupt high on both, then reset during an ACK cycle
    access(0, 1'b1, 5'h0C, 32'h0);
    access(0, 1'b1, 5'h08, 32'h0);
    access(1, 1'b1, 5'h0C, 32'h0);
    access(1, 1'b1, 5'h08, 32'h0);
    idle(2);
    sel = 1'b0; we = 1'b0; addr = 5'h00; req = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_ack", 64'(ack1), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_ack_drop", 64'(ack1), 64'd0);
    check("rst_rdata_drop", 64'(rdata1), 64'd0);
    check("rst_tip_p1", 64'(tip1), 64'd0);
    check("rst_tip_p4", 64'(tip4), 64'd0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    idle(2);
    access(0, 1'b0, 5'h08, '0);
    access(0, 1'b0, 5'h0C, '0);
    access(0, 1'b0, 5'h00, '0);
    access(0, 1'b0, 5'h04, '0);
    access(1, 1'b0, 5'h0C, '0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
